// File: rtl/alu_issue_unit.sv
// alu_issue_unit: issues one 16-bit instruction at a time to an external
// combinational ALU, holding its operands for a full cycle, then writes back.
// Ports: clk/rst; instr_valid/instr/instr_ready handshake from fetch;
// ld_en/ld_addr/ld_data direct register load; rd_addr/rd_data debug read;
// alu_type/alu_opcode/alu_r1/alu_r2 drive the ALU; alu_acc and alu_* flags
// return from it; carry/overflow/bool/zero_flag architectural flags;
// busy/done/illegal status.
module alu_issue_unit #(
  parameter int NREG = 8,
  parameter int DW   = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_valid,
  input  logic [15:0]   instr,
  output logic          instr_ready,
  input  logic          ld_en,
  input  logic [2:0]    ld_addr,
  input  logic [DW-1:0] ld_data,
  input  logic [2:0]    rd_addr,
  output logic [DW-1:0] rd_data,
  output logic [1:0]    alu_type,
  output logic [4:0]    alu_opcode,
  output logic [DW-1:0] alu_r1,
  output logic [DW-1:0] alu_r2,
  input  logic [DW-1:0] alu_acc,
  input  logic          alu_carry,
  input  logic          alu_overflow,
  input  logic          alu_bool,
  input  logic          alu_zero,
  output logic          carry_flag,
  output logic          overflow_flag,
  output logic          bool_flag,
  output logic          zero_flag,
  output logic          busy,
  output logic          done,
  output logic          illegal
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_WB
  } state_t;

  localparam logic [4:0] OP_NOT = 5'b01101;

  state_t        r_state;
  state_t        w_next;
  logic [DW-1:0] r_regs [NREG];
  logic [4:0]    r_opcode;
  logic [2:0]    r_rd;
  logic [DW-1:0] r_r1;
  logic [DW-1:0] r_r2;
  logic [DW-1:0] r_res;
  logic          r_res_c;
  logic          r_res_v;
  logic          r_res_b;
  logic          r_res_z;
  logic          r_cf;
  logic          r_vf;
  logic          r_bf;
  logic          r_zf;

  logic          w_ready;
  logic          w_busy;
  logic          w_done;
  logic          w_illegal;
  logic          w_accept;
  logic [4:0]    w_in_op;
  logic [DW-1:0] w_op1;
  logic [DW-1:0] w_op2;
  logic          w_wb_legal;
  logic          w_wb_cmp;

  function automatic logic is_reg_op(input logic [4:0] op);
    case (op)
      5'b00011, 5'b00101, 5'b01110,
      5'b01000, 5'b01001, 5'b01010,
      5'b01011, 5'b01100, 5'b01101,
      5'b10000, 5'b10010: is_reg_op = 1'b1;
      default:            is_reg_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_imm_op(input logic [4:0] op);
    case (op)
      5'b00100, 5'b00110, 5'b01111,
      5'b10001, 5'b10011: is_imm_op = 1'b1;
      default:            is_imm_op = 1'b0;
    endcase
  endfunction

  assign w_in_op = instr[15:11];
  assign w_op1   = r_regs[instr[7:5]];

  always_comb begin
    w_op2 = r_regs[instr[4:2]];
    if (is_imm_op(w_in_op))
      w_op2 = {{(DW-5){1'b0}}, instr[4:0]};
    else if (w_in_op == OP_NOT)
      w_op2 = '0;
  end

  assign w_wb_legal = is_reg_op(r_opcode) | is_imm_op(r_opcode);
  // compares (100xx) only produce flags
  assign w_wb_cmp   = (r_opcode[4:2] == 3'b100);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_ready   = 1'b0;
    w_busy    = 1'b0;
    w_done    = 1'b0;
    w_illegal = 1'b0;
    w_accept  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        // a register load blocks acceptance so the two never share an edge
        w_ready  = !ld_en;
        w_accept = instr_valid && !ld_en;
        if (w_accept)
          w_next = S_EXEC;
      end
      S_EXEC: begin
        w_busy = 1'b1;
        w_next = S_WB;
      end
      S_WB: begin
        w_busy    = 1'b1;
        w_done    = 1'b1;
        w_illegal = !w_wb_legal;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++)
        r_regs[i] <= '0;
      r_opcode <= '0;
      r_rd     <= '0;
      r_r1     <= '0;
      r_r2     <= '0;
      r_res    <= '0;
      r_res_c  <= 1'b0;
      r_res_v  <= 1'b0;
      r_res_b  <= 1'b0;
      r_res_z  <= 1'b0;
      r_cf     <= 1'b0;
      r_vf     <= 1'b0;
      r_bf     <= 1'b0;
      r_zf     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_opcode <= w_in_op;
        r_rd     <= instr[10:8];
        r_r1     <= w_op1;
        r_r2     <= w_op2;
      end
      if (r_state == S_EXEC) begin
        r_res   <= alu_acc;
        r_res_c <= alu_carry;
        r_res_v <= alu_overflow;
        r_res_b <= alu_bool;
        r_res_z <= alu_zero;
      end
      if (ld_en)
        r_regs[ld_addr] <= ld_data;
      // placed after the load so writeback wins a same-register collision
      if (r_state == S_WB && w_wb_legal) begin
        if (!w_wb_cmp)
          r_regs[r_rd] <= r_res;
        r_cf <= r_res_c;
        r_vf <= r_res_v;
        r_bf <= r_res_b;
        r_zf <= r_res_z;
      end
    end
  end

  assign instr_ready   = w_ready;
  assign busy          = w_busy;
  assign done          = w_done;
  assign illegal       = w_illegal;
  assign rd_data       = r_regs[rd_addr];
  assign alu_type      = 2'b00;
  assign alu_opcode    = r_opcode;
  assign alu_r1        = r_r1;
  assign alu_r2        = r_r2;
  assign carry_flag    = r_cf;
  assign overflow_flag = r_vf;
  assign bool_flag     = r_bf;
  assign zero_flag     = r_zf;

endmodule

// File: tb/tb_alu_issue_unit.sv
// tb_alu_issue_unit: directed table-driven bench for alu_issue_unit
// with a small behavioural ALU model closing the loop.
module tb_alu_issue_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic [15:0] instr = '0;
  logic        instr_ready;
  logic        ld_en = 1'b0;
  logic [2:0]  ld_addr = '0;
  logic [15:0] ld_data = '0;
  logic [2:0]  rd_addr = '0;
  logic [15:0] rd_data;
  logic [1:0]  alu_type;
  logic [4:0]  alu_opcode;
  logic [15:0] alu_r1;
  logic [15:0] alu_r2;
  logic [15:0] alu_acc;
  logic        alu_carry;
  logic        alu_overflow;
  logic        alu_bool;
  logic        alu_zero;
  logic        carry_flag;
  logic        overflow_flag;
  logic        bool_flag;
  logic        zero_flag;
  logic        busy;
  logic        done;
  logic        illegal;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  alu_issue_unit dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .alu_type(alu_type), .alu_opcode(alu_opcode),
    .alu_r1(alu_r1), .alu_r2(alu_r2),
    .alu_acc(alu_acc), .alu_carry(alu_carry),
    .alu_overflow(alu_overflow), .alu_bool(alu_bool), .alu_zero(alu_zero),
    .carry_flag(carry_flag), .overflow_flag(overflow_flag),
    .bool_flag(bool_flag), .zero_flag(zero_flag),
    .busy(busy), .done(done), .illegal(illegal)
  );

  // behavioural ALU; unknown opcodes return junk so stray writes show up
  logic [16:0] t;
  always_comb begin
    t            = '0;
    alu_acc      = '0;
    alu_carry    = 1'b0;
    alu_overflow = 1'b0;
    alu_bool     = 1'b0;
    case (alu_opcode)
      5'b00011, 5'b00100: begin
        t            = {1'b0, alu_r1} + {1'b0, alu_r2};
        alu_acc      = t[15:0];
        alu_carry    = t[16];
        alu_overflow = (alu_r1[15] == alu_r2[15]) &&
                       (t[15] != alu_r1[15]);
      end
      5'b00101, 5'b00110: begin
        alu_acc      = alu_r1 - alu_r2;
        alu_carry    = alu_r1 < alu_r2;
        alu_overflow = (alu_r1[15] != alu_r2[15]) &&
                       (alu_acc[15] != alu_r1[15]);
      end
      5'b01000: alu_acc = alu_r1 & alu_r2;
      5'b01001: alu_acc = alu_r1 | alu_r2;
      5'b01010: alu_acc = alu_r1 ^ alu_r2;
      5'b01011: alu_acc = alu_r1 << alu_r2[3:0];
      5'b01100: alu_acc = alu_r1 >> alu_r2[3:0];
      5'b01101: alu_acc = ~alu_r1 | alu_r2;
      5'b01110, 5'b01111: alu_acc = alu_r1 >>> alu_r2[3:0];
      5'b10000, 5'b10001: begin
        alu_bool = alu_r1 > alu_r2;
        alu_acc  = {15'b0, alu_bool};
      end
      5'b10010, 5'b10011: begin
        alu_bool = alu_r1 == alu_r2;
        alu_acc  = {15'b0, alu_bool};
      end
      default: begin
        alu_acc      = 16'hBAD0;
        alu_carry    = 1'b1;
        alu_overflow = 1'b1;
      end
    endcase
    alu_zero = (alu_acc == 16'h0000) || (alu_opcode > 5'b10011);
  end

  typedef struct {
    logic [2:0]  la;
    logic [15:0] va;
    logic [2:0]  lb;
    logic [15:0] vb;
    logic [15:0] ins;
    logic [2:0]  ca;
    logic [15:0] cv;
    logic        ec;
    logic        ev;
    logic        ez;
    logic        eb;
    logic        ei;
  } vec_t;

  vec_t vecs [11];

  function automatic logic [15:0] enc(input logic [4:0] op,
                                      input logic [2:0] rd,
                                      input logic [2:0] rs1,
                                      input logic [4:0] lo5);
    enc = {op, rd, rs1, lo5};
  endfunction

  function automatic vec_t mk(input logic [2:0] la, input logic [15:0] va,
                              input logic [2:0] lb, input logic [15:0] vb,
                              input logic [15:0] ins,
                              input logic [2:0] ca, input logic [15:0] cv,
                              input logic [4:0] f);
    vec_t v;
    v.la = la; v.va = va; v.lb = lb; v.vb = vb; v.ins = ins;
    v.ca = ca; v.cv = cv;
    {v.ec, v.ev, v.ez, v.eb, v.ei} = f;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic load(input logic [2:0] a, input logic [15:0] v);
    @(negedge clk);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = v;
    @(negedge clk);
    ld_en   = 1'b0;
  endtask

  // accept, then check the IDLE -> EXEC -> WB -> IDLE cadence
  task automatic issue(input string nm, input logic [15:0] w,
                       input logic ei);
    int n;
    @(negedge clk);
    instr_valid = 1'b1;
    instr       = w;
    #1;
    n = 0;
    while (!instr_ready && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({nm, " ready"}, instr_ready, 1);
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    chk({nm, " exec busy/ready/done"}, {busy, instr_ready, done}, 3'b100);
    @(negedge clk);
    chk({nm, " wb busy/ready/done/ill"},
        {busy, instr_ready, done, illegal}, {3'b101, ei});
    @(negedge clk);
    chk({nm, " idle busy/ready/done"}, {busy, instr_ready, done}, 3'b010);
  endtask

  initial begin
    vecs[0]  = mk(1, 16'h0005, 2, 16'h0003,
                  enc(5'b00011, 3, 1, 5'b01000), 3, 16'h0008, 5'b00000);
    vecs[1]  = mk(1, 16'hFFFF, 2, 16'h0003,
                  enc(5'b00100, 4, 1, 5'd1), 4, 16'h0000, 5'b10100);
    vecs[2]  = mk(5, 16'h0003, 2, 16'h0003,
                  enc(5'b00110, 6, 5, 5'd3), 6, 16'h0000, 5'b00100);
    vecs[3]  = mk(1, 16'h0009, 7, 16'h1234,
                  enc(5'b10000, 7, 1, 5'b01000), 7, 16'h1234, 5'b00010);
    vecs[4]  = mk(2, 16'h0003, 7, 16'h1234,
                  enc(5'b10011, 7, 2, 5'd3), 7, 16'h1234, 5'b00010);
    vecs[5]  = mk(1, 16'h0009, 2, 16'h0003,
                  enc(5'b00000, 1, 2, 5'b00100), 1, 16'h0009, 5'b00011);
    vecs[6]  = mk(1, 16'h0009, 2, 16'h0003,
                  enc(5'b11111, 2, 1, 5'b00100), 2, 16'h0003, 5'b00011);
    vecs[7]  = mk(1, 16'h0009, 2, 16'h0003,
                  enc(5'b00101, 5, 2, 5'b00100), 5, 16'hFFFA, 5'b10000);
    vecs[8]  = mk(1, 16'h00FF, 2, 16'h0003,
                  enc(5'b01101, 0, 1, 5'b01000), 0, 16'hFF00, 5'b00000);
    vecs[9]  = mk(1, 16'h00FF, 2, 16'h00FF,
                  enc(5'b01010, 0, 1, 5'b01000), 0, 16'h0000, 5'b00100);
    vecs[10] = mk(1, 16'h7FFF, 2, 16'h0001,
                  enc(5'b00011, 3, 1, 5'b01000), 3, 16'h8000, 5'b01000);

    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst ready/busy/done/ill",
        {instr_ready, busy, done, illegal}, 4'b1000);
    chk("rst flags", {carry_flag, overflow_flag, bool_flag, zero_flag}, 0);
    chk("rst alu ports", {alu_type, alu_opcode, alu_r1, alu_r2}, 0);
    for (int i = 0; i < 8; i++) begin
      rd_addr = 3'(i);
      #1;
      chk($sformatf("rst r%0d", i), rd_data, 16'h0000);
    end

    for (int k = 0; k < 11; k++) begin
      load(vecs[k].la, vecs[k].va);
      load(vecs[k].lb, vecs[k].vb);
      issue($sformatf("v%0d", k), vecs[k].ins, vecs[k].ei);
      rd_addr = vecs[k].ca;
      #1;
      chk($sformatf("v%0d rd r%0d", k, vecs[k].ca), rd_data, vecs[k].cv);
      chk($sformatf("v%0d flags cvzb", k),
          {carry_flag, overflow_flag, zero_flag, bool_flag},
          {vecs[k].ec, vecs[k].ev, vecs[k].ez, vecs[k].eb});
    end

    // reset while in EXEC abandons the instruction
    load(1, 16'h0005);
    load(2, 16'h0003);
    @(negedge clk);
    instr_valid = 1'b1;
    instr       = enc(5'b00011, 3, 1, 5'b01000);
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    chk("mid-rst exec busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("mid-rst busy/done", {busy, done}, 2'b00);
    chk("mid-rst alu_r1", alu_r1, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post-rst ready", instr_ready, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("post-rst done c%0d", i), done, 0);
    end
    rd_addr = 3;
    #1;
    chk("post-rst r3", rd_data, 16'h0000);
    chk("post-rst flags",
        {carry_flag, overflow_flag, bool_flag, zero_flag}, 0);

    // load and valid together: load wins the cycle, accept follows
    load(2, 16'h0001);
    @(negedge clk);
    ld_en       = 1'b1;
    ld_addr     = 1;
    ld_data     = 16'h0010;
    instr_valid = 1'b1;
    instr       = enc(5'b00011, 3, 1, 5'b01000);
    #1;
    chk("ld+valid ready", instr_ready, 0);
    @(negedge clk);
    ld_en = 1'b0;
    #1;
    chk("ld+valid not accepted", {busy, instr_ready}, 2'b01);
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    chk("ld+valid exec", busy, 1);
    @(negedge clk);
    chk("ld+valid done", done, 1);
    @(negedge clk);
    rd_addr = 3;
    #1;
    chk("ld+valid r3", rd_data, 16'h0011);

    // writeback beats a load to the same register on the same edge
    load(1, 16'h0002);
    load(2, 16'h0004);
    @(negedge clk);
    instr_valid = 1'b1;
    instr       = enc(5'b00011, 3, 1, 5'b01000);
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    chk("collide wb done", done, 1);
    ld_en   = 1'b1;
    ld_addr = 3;
    ld_data = 16'hDEAD;
    @(negedge clk);
    ld_en   = 1'b0;
    rd_addr = 3;
    #1;
    chk("collide r3", rd_data, 16'h0006);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
